coherency_memory_responder: RTL

Shared last-level memory responder for the 4-core MOESI system. Sits downstream of `coherency_bus` and snoops its broadcast (address, type, granted core, snoop responses). For every read or read-exclusive miss that no cache intervenes on, it returns the line on the per-core `bus_resp_valid` / `bus_resp_data` path that the cache controllers consume. It also absorbs dirty-line writebacks into a line-granular backing store.

---
 rtl/coherency_memory_responder.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/coherency_memory_responder.sv
`default_nettype none
// ============================================================================
// Module   : coherency_memory_responder
// Purpose  : Last-level memory responder for the 4-core MOESI bus. Snoops
//            the bus broadcast, queues READ/READ-EXCLUSIVE misses that no
//            cache intervenes on, and returns the line to the requesting core
//            after a fixed array latency. Absorbs dirty-line writebacks into
//            a line-granular backing store (writebacks win over queued reads).
// Ports    : clk, rst_n (async, active-low)
//            bus_valid/bus_type/bus_addr/granted_core_id/snoop_resp : snoop in
//            wb_valid/wb_addr/wb_data -> wb_ready                   : writeback
//            bus_resp_valid/bus_resp_data                           : response
//            mem_busy, overflow_err, interv_count                   : status
// Revision : 1.0 - initial release
// ============================================================================
module coherency_memory_responder #(
  parameter int NUM_CORES   = 4,
  parameter int ADDR_WIDTH  = 64,
  parameter int LINE_BYTES  = 64,
  parameter int DATA_WIDTH  = LINE_BYTES * 8,
  parameter int MEM_LINES   = 1024,
  parameter int MEM_LATENCY = 4,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  bus_valid,
  input  logic [1:0]            bus_type,
  input  logic [ADDR_WIDTH-1:0] bus_addr,
  input  logic [1:0]            granted_core_id,
  input  logic [NUM_CORES-1:0]  snoop_resp,
  input  logic                  wb_valid,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  wb_ready,
  output logic [NUM_CORES-1:0]  bus_resp_valid,
  output logic [DATA_WIDTH-1:0] bus_resp_data,
  output logic                  mem_busy,
  output logic                  overflow_err,
  output logic [15:0]           interv_count
);

  localparam int C_OFF_W = $clog2(LINE_BYTES);
  localparam int C_IDX_W = $clog2(MEM_LINES);
  localparam int C_PTR_W = $clog2(FIFO_DEPTH);
  localparam int C_CNT_W = C_PTR_W + 1;
  localparam int C_LAT_W = $clog2(MEM_LATENCY + 1);
  localparam int C_ENT_W = 2 + C_IDX_W;

  localparam logic [C_CNT_W-1:0]   C_FULL     = C_CNT_W'(FIFO_DEPTH);
  localparam logic [C_CNT_W-1:0]   C_BUSY_THR = C_CNT_W'(FIFO_DEPTH - 1);
  localparam logic [C_LAT_W-1:0]   C_LAT_LOAD = C_LAT_W'(MEM_LATENCY - 1);
  localparam logic [NUM_CORES-1:0] C_ONE      = NUM_CORES'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WB     = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t                r_state;
  logic [C_LAT_W-1:0]    r_lat_cnt;
  logic [1:0]            r_svc_core;
  logic [C_IDX_W-1:0]    r_svc_idx;
  logic [NUM_CORES-1:0]  r_resp_valid;
  logic [DATA_WIDTH-1:0] r_resp_data;
  logic                  r_wb_ready;

  logic [C_ENT_W-1:0]    r_fifo [FIFO_DEPTH];
  logic [C_PTR_W-1:0]    r_wr_ptr;
  logic [C_PTR_W-1:0]    r_rd_ptr;
  logic [C_CNT_W-1:0]    r_count;
  logic                  r_mem_busy;
  logic                  r_overflow;
  logic [15:0]           r_interv_cnt;

  // Backing store: no reset, contents survive rst_n.
  logic [DATA_WIDTH-1:0] r_mem [MEM_LINES];

  logic [C_IDX_W-1:0]    w_bus_idx;
  logic [C_IDX_W-1:0]    w_wb_idx;
  logic                  w_is_rd;
  logic                  w_interv;
  logic                  w_push_req;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop;
  logic [C_CNT_W-1:0]    w_count_next;
  logic                  w_unused_ok;

  assign w_bus_idx  = bus_addr[C_OFF_W +: C_IDX_W];
  assign w_wb_idx   = wb_addr[C_OFF_W +: C_IDX_W];
  assign w_is_rd    = bus_valid && ((bus_type == 2'b01) || (bus_type == 2'b10));
  assign w_interv   = |snoop_resp;
  assign w_push_req = w_is_rd && !w_interv;
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == C_FULL);
  // Pop condition mirrors the IDLE->ACCESS branch of the FSM exactly.
  assign w_pop      = (r_state == S_IDLE) && !wb_valid && !w_empty;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_drop     = w_push_req && w_full && !w_pop;

  // Tag/offset bits are intentionally ignored (addresses alias).
  assign w_unused_ok = ^{bus_addr[ADDR_WIDTH-1:C_OFF_W+C_IDX_W], bus_addr[C_OFF_W-1:0],
                         wb_addr[ADDR_WIDTH-1:C_OFF_W+C_IDX_W], wb_addr[C_OFF_W-1:0]};

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop)
      w_count_next = r_count + 1'b1;
    else if (!w_push && w_pop)
      w_count_next = r_count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_fifo[r_wr_ptr] <= {granted_core_id, w_bus_idx};
  end

  always_ff @(posedge clk) begin
    if (r_state == S_WB)
      r_mem[w_wb_idx] <= wb_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_mem_busy   <= 1'b0;
      r_overflow   <= 1'b0;
      r_interv_cnt <= 16'd0;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count    <= w_count_next;
      r_mem_busy <= (w_count_next >= C_BUSY_THR);
      if (w_drop)
        r_overflow <= 1'b1;
      if (w_is_rd && w_interv && (r_interv_cnt != 16'hFFFF))
        r_interv_cnt <= r_interv_cnt + 16'd1;
    end
  end

  // Service FSM. Outputs are registered: wb_ready is high for the WB cycle,
  // bus_resp_valid is high for the RESP cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_lat_cnt    <= '0;
      r_svc_core   <= 2'd0;
      r_svc_idx    <= '0;
      r_resp_valid <= '0;
      r_resp_data  <= '0;
      r_wb_ready   <= 1'b0;
    end else begin
      r_resp_valid <= '0;
      r_wb_ready   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (wb_valid) begin
            r_state    <= S_WB;
            r_wb_ready <= 1'b1;
          end else if (!w_empty) begin
            {r_svc_core, r_svc_idx} <= r_fifo[r_rd_ptr];
            r_lat_cnt               <= C_LAT_LOAD;
            r_state                 <= S_ACCESS;
          end
        end
        S_WB: begin
          r_state <= S_IDLE;
        end
        S_ACCESS: begin
          if (r_lat_cnt == '0) begin
            r_resp_valid <= C_ONE << r_svc_core;
            r_resp_data  <= r_mem[r_svc_idx];
            r_state      <= S_RESP;
          end else begin
            r_lat_cnt <= r_lat_cnt - 1'b1;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign wb_ready       = r_wb_ready;
  assign bus_resp_valid = r_resp_valid;
  assign bus_resp_data  = r_resp_data;
  assign mem_busy       = r_mem_busy;
  assign overflow_err   = r_overflow;
  assign interv_count   = r_interv_cnt;

endmodule
`default_nettype wire
